// File: rtl/cv32e40p_wb_result_arbiter.sv
// Result write-port arbiter: merges NUM_SRC buffered producers onto one
// register-file write port through a single registered output stage.
module cv32e40p_wb_result_arbiter #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned RR_EN      = 0,
  localparam int unsigned SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  input  logic [NUM_SRC-1:0]               src_valid_i,
  output logic [NUM_SRC-1:0]               src_ready_o,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]    src_waddr_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_wdata_i,
  input  logic                             wb_stall_i,
  output logic                             wb_we_o,
  output logic [ADDR_WIDTH-1:0]            wb_waddr_o,
  output logic [DATA_WIDTH-1:0]            wb_wdata_o,
  output logic [SRC_W-1:0]                 wb_src_o,
  output logic                             contention_o,
  output logic                             busy_o
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [NUM_SRC-1:0]    ready;
  logic [NUM_SRC-1:0]    accept;
  logic [NUM_SRC-1:0]    nonempty;
  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    gnt;
  logic [ADDR_WIDTH-1:0] in_addr   [NUM_SRC];
  logic [DATA_WIDTH-1:0] in_data   [NUM_SRC];
  logic [ADDR_WIDTH-1:0] head_addr [NUM_SRC];
  logic [DATA_WIDTH-1:0] head_data [NUM_SRC];

  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  arb_en;
  logic                  multi_req;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
    logic [ADDR_WIDTH-1:0] mem_addr [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign in_addr[g]   = src_waddr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_data[g]   = src_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign nonempty[g]  = (count != '0);
    assign full         = (count == CNT_W'(BUF_DEPTH));
    assign ready[g]     = ~full & ~flush_i;
    // Writes to x0 complete the handshake but never reach the FIFO.
    assign accept[g]    = src_valid_i[g] & ready[g] & (in_addr[g] != '0);
    assign req[g]       = nonempty[g] | accept[g];
    assign head_addr[g] = mem_addr[rd_ptr];
    assign head_data[g] = mem_data[rd_ptr];
    assign pop          = gnt[g] & nonempty[g];
    // A granted bypass (empty FIFO) goes straight to the output stage.
    assign push         = accept[g] & ~(gnt[g] & ~nonempty[g]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= (rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_addr[wr_ptr] <= in_addr[g];
        mem_data[wr_ptr] <= in_data[g];
      end
    end
  end

  assign src_ready_o = ready;
  assign arb_en      = (~wb_we_o | ~wb_stall_i) & ~flush_i;

  always_comb begin : arb
    int unsigned idx;
    int unsigned n_req;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    n_req   = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      n_req = n_req + 32'(req[k]);
      idx   = k + ((RR_EN != 0) ? 32'(rr_ptr) : 32'd0);
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (arb_en && !gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = SRC_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
    multi_req = (n_req >= 2);
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_addr = nonempty[i] ? head_addr[i] : in_addr[i];
        sel_data = nonempty[i] ? head_data[i] : in_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_o      <= 1'b0;
      wb_waddr_o   <= '0;
      wb_wdata_o   <= '0;
      wb_src_o     <= '0;
      contention_o <= 1'b0;
      rr_ptr       <= '0;
    end else if (flush_i) begin
      wb_we_o      <= 1'b0;
      contention_o <= 1'b0;
    end else if (arb_en) begin
      wb_we_o      <= gnt_any;
      contention_o <= multi_req;
      if (gnt_any) begin
        wb_waddr_o <= sel_addr;
        wb_wdata_o <= sel_data;
        wb_src_o   <= gnt_idx;
        rr_ptr     <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end
    end else begin
      contention_o <= 1'b0;
    end
  end

  assign busy_o = (|nonempty) | wb_we_o;

endmodule

// File: tb/tb_cv32e40p_wb_result_arbiter.sv
// Directed bench for cv32e40p_wb_result_arbiter: fixed-priority instance for
// most scenarios, a round-robin instance for fairness.
module tb_cv32e40p_wb_result_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [17:0] src_waddr;
  logic [95:0] src_wdata;
  logic        wb_stall;
  logic        wb_we;
  logic [5:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [1:0]  wb_src;
  logic        contention;
  logic        busy;

  logic [2:0]  rr_valid;
  logic [2:0]  rr_ready;
  logic [17:0] rr_waddr_in;
  logic [95:0] rr_wdata_in;
  logic        rr_we;
  logic [5:0]  rr_waddr;
  logic [31:0] rr_wdata;
  logic [1:0]  rr_src;
  logic        rr_contention;
  logic        rr_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cv32e40p_wb_result_arbiter #(
    .NUM_SRC(3), .DATA_WIDTH(32), .ADDR_WIDTH(6), .BUF_DEPTH(2), .RR_EN(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_waddr_i(src_waddr), .src_wdata_i(src_wdata),
    .wb_stall_i(wb_stall), .wb_we_o(wb_we), .wb_waddr_o(wb_waddr),
    .wb_wdata_o(wb_wdata), .wb_src_o(wb_src),
    .contention_o(contention), .busy_o(busy)
  );

  cv32e40p_wb_result_arbiter #(
    .NUM_SRC(3), .DATA_WIDTH(32), .ADDR_WIDTH(6), .BUF_DEPTH(2), .RR_EN(1)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
    .src_valid_i(rr_valid), .src_ready_o(rr_ready),
    .src_waddr_i(rr_waddr_in), .src_wdata_i(rr_wdata_in),
    .wb_stall_i(1'b0), .wb_we_o(rr_we), .wb_waddr_o(rr_waddr),
    .wb_wdata_o(rr_wdata), .wb_src_o(rr_src),
    .contention_o(rr_contention), .busy_o(rr_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic [5:0] a, input logic [31:0] d);
    src_valid[s]       = v;
    src_waddr[s*6 +: 6]  = a;
    src_wdata[s*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wb_stall = 1'b0;
    src_valid = '0; src_waddr = '0; src_wdata = '0;
    rr_valid = '0; rr_waddr_in = '0; rr_wdata_in = '0;
    #12;
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h expected 0", wb_we); end
    n_checks++; if (wb_waddr !== 6'd0) begin n_fail++; $display("FAIL reset_waddr: got %0h expected 0", wb_waddr); end
    n_checks++; if (wb_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", wb_wdata); end
    n_checks++; if (wb_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0h expected 0", wb_src); end
    n_checks++; if (contention !== 1'b0) begin n_fail++; $display("FAIL reset_contention: got %0h expected 0", contention); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    rst_n = 1'b1;
    step();
    n_checks++; if (src_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %0h expected 7", src_ready); end
    n_checks++; if (rr_ready !== 3'b111) begin n_fail++; $display("FAIL reset_rr_ready: got %0h expected 7", rr_ready); end
  endtask

  task automatic test_single();
    drive(0, 1'b1, 6'd5, 32'hDEAD_BEEF);
    step();
    drive(0, 1'b0, 6'd0, 32'h0);
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %0h expected 1", wb_we); end
    n_checks++; if (wb_waddr !== 6'd5) begin n_fail++; $display("FAIL single_waddr: got %0h expected 5", wb_waddr); end
    n_checks++; if (wb_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_wdata: got %0h expected deadbeef", wb_wdata); end
    n_checks++; if (wb_src !== 2'd0) begin n_fail++; $display("FAIL single_src: got %0h expected 0", wb_src); end
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL single_we_off: got %0h expected 0", wb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %0h expected 0", busy); end
  endtask

  task automatic test_fixed_contention();
    drive(0, 1'b1, 6'd1, 32'h11);
    drive(2, 1'b1, 6'd3, 32'h33);
    step();
    drive(0, 1'b0, 6'd0, 32'h0);
    drive(2, 1'b0, 6'd0, 32'h0);
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL fp_we1: got %0h expected 1", wb_we); end
    n_checks++; if (wb_waddr !== 6'd1) begin n_fail++; $display("FAIL fp_waddr1: got %0h expected 1", wb_waddr); end
    n_checks++; if (wb_wdata !== 32'h11) begin n_fail++; $display("FAIL fp_wdata1: got %0h expected 11", wb_wdata); end
    n_checks++; if (contention !== 1'b1) begin n_fail++; $display("FAIL fp_contention1: got %0h expected 1", contention); end
    step();
    n_checks++; if (wb_waddr !== 6'd3) begin n_fail++; $display("FAIL fp_waddr2: got %0h expected 3", wb_waddr); end
    n_checks++; if (wb_wdata !== 32'h33) begin n_fail++; $display("FAIL fp_wdata2: got %0h expected 33", wb_wdata); end
    n_checks++; if (wb_src !== 2'd2) begin n_fail++; $display("FAIL fp_src2: got %0h expected 2", wb_src); end
    n_checks++; if (contention !== 1'b0) begin n_fail++; $display("FAIL fp_contention2: got %0h expected 0", contention); end
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL fp_we_off: got %0h expected 0", wb_we); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    rr_valid    = 3'b111;
    rr_waddr_in = {6'd3, 6'd2, 6'd1};
    rr_wdata_in = {32'hC, 32'hB, 32'hA};
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++; if (rr_we !== 1'b1) begin n_fail++; $display("FAIL rr_we[%0d]: got %0h expected 1", c, rr_we); end
      n_checks++; if (rr_src !== exp_src[c]) begin n_fail++; $display("FAIL rr_src[%0d]: got %0h expected %0h", c, rr_src, exp_src[c]); end
      n_checks++; if (rr_contention !== 1'b1) begin n_fail++; $display("FAIL rr_contention[%0d]: got %0h expected 1", c, rr_contention); end
    end
    rr_valid = '0;
    for (int c = 0; c < 8; c++) step();
    n_checks++; if (rr_busy !== 1'b0) begin n_fail++; $display("FAIL rr_drained: got %0h expected 0", rr_busy); end
  endtask

  task automatic test_backpressure();
    wb_stall = 1'b1;
    drive(1, 1'b1, 6'd11, 32'hA1);
    step();
    n_checks++; if (wb_waddr !== 6'd11) begin n_fail++; $display("FAIL bp_staged: got %0h expected 0b", wb_waddr); end
    drive(1, 1'b1, 6'd12, 32'hA2);
    step();
    drive(1, 1'b1, 6'd13, 32'hA3);
    step();
    n_checks++; if (src_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %0h expected 0", src_ready[1]); end
    drive(1, 1'b1, 6'd14, 32'hA4);
    step();
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL bp_hold_we: got %0h expected 1", wb_we); end
    n_checks++; if (wb_waddr !== 6'd11) begin n_fail++; $display("FAIL bp_hold_waddr: got %0h expected 0b", wb_waddr); end
    n_checks++; if (wb_wdata !== 32'hA1) begin n_fail++; $display("FAIL bp_hold_wdata: got %0h expected a1", wb_wdata); end
    n_checks++; if (src_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_still_low: got %0h expected 0", src_ready[1]); end
    wb_stall = 1'b0;
    step();
    n_checks++; if (wb_wdata !== 32'hA2) begin n_fail++; $display("FAIL bp_order2: got %0h expected a2", wb_wdata); end
    n_checks++; if (src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %0h expected 1", src_ready[1]); end
    step();
    drive(1, 1'b0, 6'd0, 32'h0);
    n_checks++; if (wb_wdata !== 32'hA3) begin n_fail++; $display("FAIL bp_order3: got %0h expected a3", wb_wdata); end
    step();
    n_checks++; if (wb_waddr !== 6'd14) begin n_fail++; $display("FAIL bp_order4_addr: got %0h expected 0e", wb_waddr); end
    n_checks++; if (wb_wdata !== 32'hA4) begin n_fail++; $display("FAIL bp_order4: got %0h expected a4", wb_wdata); end
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL bp_done: got %0h expected 0", wb_we); end
  endtask

  task automatic test_x0_drop();
    drive(1, 1'b1, 6'd0, 32'h99);
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %0h expected 0", wb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %0h expected 0", busy); end
    drive(1, 1'b1, 6'd32, 32'h5);
    step();
    drive(1, 1'b0, 6'd0, 32'h0);
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL f0_we: got %0h expected 1", wb_we); end
    n_checks++; if (wb_waddr !== 6'd32) begin n_fail++; $display("FAIL f0_waddr: got %0h expected 20", wb_waddr); end
    n_checks++; if (wb_wdata !== 32'h5) begin n_fail++; $display("FAIL f0_wdata: got %0h expected 5", wb_wdata); end
    n_checks++; if (wb_src !== 2'd1) begin n_fail++; $display("FAIL f0_src: got %0h expected 1", wb_src); end
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL f0_we_off: got %0h expected 0", wb_we); end
  endtask

  task automatic test_flush();
    wb_stall = 1'b1;
    drive(0, 1'b1, 6'd7, 32'h70);
    step();
    drive(0, 1'b1, 6'd8, 32'h80);
    step();
    drive(0, 1'b1, 6'd9, 32'h90);
    step();
    drive(0, 1'b0, 6'd0, 32'h0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %0h expected 1", busy); end
    n_checks++; if (src_ready[0] !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %0h expected 0", src_ready[0]); end
    flush = 1'b1;
    #1;
    n_checks++; if (src_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready: got %0h expected 0", src_ready); end
    step();
    flush = 1'b0;
    wb_stall = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %0h expected 0", busy); end
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL flush_we: got %0h expected 0", wb_we); end
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL flush_no_write: got %0h expected 0", wb_we); end
    n_checks++; if (src_ready !== 3'b111) begin n_fail++; $display("FAIL flush_ready_back: got %0h expected 7", src_ready); end
  endtask

  task automatic test_reset_mid();
    wb_stall = 1'b1;
    drive(2, 1'b1, 6'd20, 32'hC0);
    step();
    drive(2, 1'b1, 6'd21, 32'hC1);
    step();
    drive(2, 1'b0, 6'd0, 32'h0);
    n_checks++; if (wb_waddr !== 6'd20) begin n_fail++; $display("FAIL rstm_staged: got %0h expected 14", wb_waddr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rstm_we: got %0h expected 0", wb_we); end
    n_checks++; if (wb_waddr !== 6'd0) begin n_fail++; $display("FAIL rstm_waddr: got %0h expected 0", wb_waddr); end
    n_checks++; if (wb_wdata !== 32'd0) begin n_fail++; $display("FAIL rstm_wdata: got %0h expected 0", wb_wdata); end
    n_checks++; if (wb_src !== 2'd0) begin n_fail++; $display("FAIL rstm_src: got %0h expected 0", wb_src); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstm_busy: got %0h expected 0", busy); end
    #3;
    rst_n = 1'b1;
    wb_stall = 1'b0;
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rstm_no_write: got %0h expected 0", wb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstm_busy_after: got %0h expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_contention();
    test_round_robin();
    test_backpressure();
    test_x0_drop();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
